// File: rtl/tie_pkg.sv
// ---------------------------------------------------------------------------
// tie_pkg
//   Shared definitions for the don't-care tie resolution stage. The policy
//   encoding is also used by the mapper test harness and the tie-cell lowering
//   pass, so its values are fixed: 0=GND, 1=VCC, 2=HOLD, 3=reserved (acts as GND).
//   Also holds the skid-buffer state encoding used by tie_resolve_skid.
// ---------------------------------------------------------------------------
package tie_pkg;

    // Tie policy applied to every don't-care bit of an accepted word.
    typedef enum logic [1:0] {
        TIE_GND  = 2'd0,
        TIE_VCC  = 2'd1,
        TIE_HOLD = 2'd2,
        TIE_RSVD = 2'd3   // reserved encoding, resolved exactly like TIE_GND
    } dc_policy_e;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,  // main entry invalid
        ST_ONE   = 2'd1,  // main entry valid, skid entry invalid
        ST_FULL  = 2'd2   // main and skid entries valid
    } skid_state_e;

endpackage : tie_pkg

// File: rtl/tie_resolve.sv
// ---------------------------------------------------------------------------
// tie_resolve
//   Combinational resolver: replaces every don't-care bit of a word with the
//   tie value selected by the policy and counts how many bits were resolved.
// Ports
//   i_data    in  WIDTH  raw data, don't-care positions carry arbitrary values
//   i_known   in  WIDTH  1 = bit defined, 0 = bit is don't-care
//   i_hold    in  WIDTH  last resolved word (source for TIE_HOLD)
//   i_policy  in  enum   tie policy for this word
//   o_word    out WIDTH  resolved word, fully defined
//   o_dc_cnt  out CW     number of don't-care bits in this word
// ---------------------------------------------------------------------------
module tie_resolve
    import tie_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [WIDTH-1:0] i_known,
    input  logic [WIDTH-1:0] i_hold,
    input  dc_policy_e       i_policy,
    output logic [WIDTH-1:0] o_word,
    output logic [CW-1:0]    o_dc_cnt
);

    logic [WIDTH-1:0] w_fill;

    // Fill pattern used for don't-care positions; reserved policy falls to GND.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        w_fill = '0;
        case (i_policy)
            TIE_VCC:  w_fill = '1;
            TIE_HOLD: w_fill = i_hold;
            default:  w_fill = '0;
        endcase
    end

    // Known bits pass through; don't-care bits take the fill pattern. The
    // raw value of a don't-care bit is masked off, so x on i_data cannot leak.
    assign o_word = (i_data & i_known) | (w_fill & ~i_known);

    always_comb begin
        o_dc_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_dc_cnt = o_dc_cnt + CW'(!i_known[i]);
        end
    end

endmodule : tie_resolve

// File: rtl/tie_resolve_skid.sv
// ---------------------------------------------------------------------------
// tie_resolve_skid
//   Registered stream stage in front of the AND/tie-cell stage. Resolves
//   don't-care bits at accept time, buffers up to two words in a main/skid
//   pair so in_ready is purely registered, and keeps a saturating count of
//   resolved don't-care bits.
// Ports
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous active-high reset
//   policy     in   2        dc_policy_e value, sampled on accept
//   in_valid   in   1        upstream word valid
//   in_ready   out  1        stage can accept a word this cycle (registered)
//   in_data    in   WIDTH    raw data
//   in_known   in   WIDTH    1 = defined bit, 0 = don't-care
//   out_valid  out  1        resolved word valid
//   out_ready  in   1        downstream accepts
//   out_data   out  WIDTH    resolved data
//   cnt_clr    in   1        clear dc_count (applied before this cycle's add)
//   dc_count   out  COUNT_W  saturating don't-care bit count
// ---------------------------------------------------------------------------
module tie_resolve_skid
    import tie_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         policy,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [WIDTH-1:0]   in_known,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    input  logic               cnt_clr,
    output logic [COUNT_W-1:0] dc_count
);

    localparam int                 CW      = $clog2(WIDTH + 1);
    // One spare bit over the wider addend so the sum can never wrap before saturation.
    localparam int                 SUM_W   = ((COUNT_W > CW) ? COUNT_W : CW) + 1;
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    skid_state_e        r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_main_data;
    logic [WIDTH-1:0]   r_skid_data;
    logic [WIDTH-1:0]   r_hold;
    logic [COUNT_W-1:0] r_count;

    logic               w_acc;
    logic               w_emit;
    logic [WIDTH-1:0]   w_res;
    logic [CW-1:0]      w_pop;
    logic [SUM_W-1:0]   w_sum;
    logic [COUNT_W-1:0] w_count_next;

    assign w_acc  = in_valid && r_in_ready;
    assign w_emit = r_out_valid && out_ready;

    tie_resolve #(
        .WIDTH (WIDTH)
    ) u_resolve (
        .i_data   (in_data),
        .i_known  (in_known),
        .i_hold   (r_hold),
        .i_policy (dc_policy_e'(policy)),
        .o_word   (w_res),
        .o_dc_cnt (w_pop)
    );

    // ------------------------------------------------------------------
    // Skid FSM. in_ready and out_valid are registered outputs derived from
    // the next state, so out_ready never reaches in_ready combinationally.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            // NOTE: the buffer entries are reset as well so out_data is a defined 0 after reset instead of stale contents.
            r_main_data <= '0;
            r_skid_data <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        r_main_data <= w_res;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_acc && !w_emit) begin
                        // Main is stalled: park the new word and stop accepting.
                        r_skid_data <= w_res;
                        r_in_ready  <= 1'b0;
                        r_state     <= ST_FULL;
                    end else if (w_emit && !w_acc) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end else if (w_emit && w_acc) begin
                        // Pass-through: new word replaces the emitted one, no bubble.
                        r_main_data <= w_res;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only an emit can occur.
                    if (w_emit) begin
                        r_main_data <= r_skid_data;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_ONE;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Hold register tracks the last resolved word for TIE_HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else if (w_acc) begin
            r_hold <= w_res;
        end
    end

    // ------------------------------------------------------------------
    // Statistics counter: clear is applied before this cycle's addition,
    // then the result saturates at all-ones.
    // ------------------------------------------------------------------
    always_comb begin
        w_sum = (cnt_clr ? '0 : SUM_W'(r_count)) + (w_acc ? SUM_W'(w_pop) : '0);
        if (w_sum > SUM_W'(CNT_MAX)) begin
            w_count_next = CNT_MAX;
        end else begin
            w_count_next = w_sum[COUNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main_data;
    assign dc_count  = r_count;

endmodule : tie_resolve_skid

// File: tb/tb_tie_resolve_skid.sv
// ---------------------------------------------------------------------------
// tb_tie_resolve_skid
//   Drives two instances (COUNT_W=16 and COUNT_W=4) with identical directed
//   stimulus. A queue-based model of the stage predicts handshakes, data and
//   both counters; literal expectations pin the model at key points.
// ---------------------------------------------------------------------------
module tb_tie_resolve_skid;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       policy;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] in_known;
    logic             out_ready;
    logic             cnt_clr;

    logic             in_ready,  in_ready4;
    logic             out_valid, out_valid4;
    logic [WIDTH-1:0] out_data,  out_data4;
    logic [15:0]      dc_count;
    logic [3:0]       dc_count4;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    tie_resolve_skid #(.WIDTH(WIDTH), .COUNT_W(16)) dut (
        .clk(clk), .rst(rst), .policy(policy),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_known(in_known),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cnt_clr(cnt_clr), .dc_count(dc_count)
    );

    tie_resolve_skid #(.WIDTH(WIDTH), .COUNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .policy(policy),
        .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_known(in_known),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .cnt_clr(cnt_clr), .dc_count(dc_count4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [WIDTH-1:0] m_q[$];      // words in flight, oldest first
    logic [WIDTH-1:0] m_hold = '0;
    int               m_c16  = 0;
    int               m_c4   = 0;
    bit               m_live = 1'b0;

    function automatic logic [WIDTH-1:0] model_resolve(input logic [WIDTH-1:0] d,
            input logic [WIDTH-1:0] k, input logic [1:0] p, input logic [WIDTH-1:0] h);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            if (k[i])           r[i] = d[i];
            else if (p == 2'd1) r[i] = 1'b1;
            else if (p == 2'd2) r[i] = h[i];
            else                r[i] = 1'b0;
        end
        return r;
    endfunction

    function automatic int sat_add(input int base, input int add, input int max);
        return (base + add > max) ? max : base + add;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_hold = '0;
            m_c16  = 0;
            m_c4   = 0;
            m_live = 1'b1;
        end else if (m_live) begin
            bit               acc, emit;
            int               pc;
            logic [WIDTH-1:0] res;
            acc  = in_valid && (m_q.size() < 2);
            emit = (m_q.size() > 0) && out_ready;
            pc   = $countones(~in_known);
            res  = model_resolve(in_data, in_known, policy, m_hold);
            if (cnt_clr) begin
                m_c16 = 0;
                m_c4  = 0;
            end
            if (acc) begin
                m_c16 = sat_add(m_c16, pc, 65535);
                m_c4  = sat_add(m_c4, pc, 15);
            end
            if (emit) void'(m_q.pop_front());
            if (acc) begin
                m_q.push_back(res);
                m_hold = res;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int dut_emits = 0;

    always @(negedge clk) begin
        if (m_live) begin
            check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
            check("in_ready",  32'(in_ready),  32'(m_q.size() < 2));
            check("in_ready4", 32'(in_ready4), 32'(m_q.size() < 2));
            check("out_valid4", 32'(out_valid4), 32'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                check("out_data",  32'(out_data),  32'(m_q[0]));
                check("out_data4", 32'(out_data4), 32'(m_q[0]));
            end
            check("dc_count",  32'(dc_count),  32'(m_c16));
            check("dc_count4", 32'(dc_count4), 32'(m_c4));
            if (out_valid && out_ready) dut_emits++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] k,
                       input logic [1:0] p, input logic ordy, input logic clr);
        in_valid  = v;
        in_data   = d;
        in_known  = k;
        policy    = p;
        out_ready = ordy;
        cnt_clr   = clr;
    endtask

    initial begin
        int emits0;
        rst = 1'b1;
        put(1'b0, 8'h00, 8'hFF, 2'd0, 1'b1, 1'b0);
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_data",  32'(out_data),  32'h00);
        check("rst_dc_count",  32'(dc_count),  32'd0);
        rst = 1'b0;

        // 1: GND policy
        put(1'b1, 8'hA5, 8'h0F, 2'd0, 1'b1, 1'b0);
        tick();
        check("t1_out_data", 32'(out_data), 32'h05);
        check("t1_dc_count", 32'(dc_count), 32'd4);

        // 2: VCC (with clear), then HOLD
        put(1'b1, 8'h00, 8'h00, 2'd1, 1'b1, 1'b1);
        tick();
        check("t2_vcc_data", 32'(out_data), 32'hFF);
        put(1'b1, 8'h00, 8'hF0, 2'd2, 1'b1, 1'b0);
        tick();
        check("t2_hold_data", 32'(out_data), 32'h0F);
        check("t2_dc_count",  32'(dc_count), 32'd12);
        put(1'b0, 8'h00, 8'hFF, 2'd0, 1'b1, 1'b0);
        tick();

        // 3: backpressure
        put(1'b1, 8'h11, 8'hFF, 2'd0, 1'b0, 1'b0);
        tick();
        put(1'b1, 8'h22, 8'hFF, 2'd0, 1'b0, 1'b0);
        tick();
        check("t3_full_in_ready", 32'(in_ready), 32'd0);
        put(1'b1, 8'h33, 8'hFF, 2'd0, 1'b0, 1'b0);
        tick();
        check("t3_stall_data_a", 32'(out_data), 32'h11);
        tick();
        check("t3_stall_data_b", 32'(out_data), 32'h11);
        out_ready = 1'b1;
        tick();
        check("t3_release_data", 32'(out_data), 32'h22);
        check("t3_release_rdy",  32'(in_ready), 32'd1);
        tick();
        check("t3_third_data", 32'(out_data), 32'h33);
        in_valid = 1'b0;
        tick();
        check("t3_drained", 32'(out_valid), 32'd0);

        // 4: streaming, 20 words, mixed policies
        emits0 = dut_emits;
        for (int i = 0; i < 20; i++) begin
            put(1'b1, 8'(i * 37 + 3), 8'(i * 13), 2'(i % 4), 1'b1, 1'b0);
            tick();
            check("t4_no_bubble", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("t4_emit_count", 32'(dut_emits - emits0), 32'd20);

        // 5: saturation on the 4-bit counter, clear with concurrent word
        put(1'b1, 8'h00, 8'h00, 2'd0, 1'b1, 1'b1);
        tick();
        check("t5_c4_first", 32'(dc_count4), 32'd8);
        cnt_clr = 1'b0;
        tick();
        tick();
        check("t5_c4_sat", 32'(dc_count4), 32'd15);
        check("t5_c16",    32'(dc_count),  32'd24);
        put(1'b1, 8'h00, 8'hFE, 2'd0, 1'b1, 1'b1);
        tick();
        check("t5_c4_clr", 32'(dc_count4), 32'd1);
        check("t5_c16_clr", 32'(dc_count), 32'd1);
        put(1'b0, 8'h00, 8'hFF, 2'd0, 1'b1, 1'b0);
        tick();

        // 6: reset with a full buffer
        put(1'b1, 8'h5A, 8'h00, 2'd1, 1'b0, 1'b0);
        tick();
        tick();
        check("t6_full", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("t6_rst_valid",  32'(out_valid), 32'd0);
        check("t6_rst_ready",  32'(in_ready),  32'd1);
        check("t6_rst_count",  32'(dc_count),  32'd0);
        rst = 1'b0;
        put(1'b1, 8'hAB, 8'h00, 2'd2, 1'b1, 1'b0);
        tick();
        check("t6_hold_cleared", 32'(out_data), 32'h00);
        check("t6_hold_valid",   32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_tie_resolve_skid
